uart_baud_gen: RTL

Parametrised fractional baud-rate generator for the UART. Produces an oversampling tick (`os_tick`) for the receiver and a 1x bit tick (`tx_baud`) for the transmitter. Both come from one programmable integer+fractional divisor, replacing the fixed power-of-two select scheme. The divisor can be reloaded safely at run time, and the receiver can re-align the tick phase to a detected start edge.

---
 rtl/uart_baud_pkg.sv | 19 +
 rtl/uart_frac_acc.sv | 31 +++
 rtl/uart_baud_gen.sv | 116 +++++++++++
 3 files changed

// File: rtl/uart_baud_pkg.sv
// Shared constants and elaboration helpers for the UART baud-rate generator.
package uart_baud_pkg;

    localparam int          DEF_DIV_W      = 16;
    localparam int          DEF_FRAC_W     = 4;
    localparam int          DEF_OVERSAMPLE = 16;
    localparam logic [15:0] DEF_RESET_DIV  = 16'd54;

    // Oversample ratio must be a power of two between 4 and 64.
    function automatic bit oversample_ok(input int os);
        return (os >= 4) && (os <= 64) && ((os & (os - 1)) == 0);
    endfunction

    // Width of the phase counter that walks one bit period of oversample ticks.
    function automatic int phase_width(input int os);
        return $clog2(os);
    endfunction

endpackage

// File: rtl/uart_frac_acc.sv
// Fractional accumulator: adds the fraction on every tick and reports the
// overflow that stretches the following period by one clock.
module uart_frac_acc #(
    parameter int FRAC_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              tick,
    input  logic [FRAC_W-1:0] frac,
    output logic              carry
);

    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;

    assign sum   = {1'b0, acc} + {1'b0, frac};
    assign carry = sum[FRAC_W];

    // Accumulate on tick; clear has priority so a fresh period starts at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (tick) begin
            acc <= sum[FRAC_W-1:0];
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// Fractional baud-rate generator: oversample tick for RX, 1x bit tick for TX,
// run-time divisor reload and RX phase re-alignment.
module uart_baud_gen
    import uart_baud_pkg::*;
#(
    parameter int               DIV_W      = DEF_DIV_W,
    parameter int               FRAC_W     = DEF_FRAC_W,
    parameter int               OVERSAMPLE = DEF_OVERSAMPLE,
    parameter logic [DIV_W-1:0] RESET_DIV  = DIV_W'(DEF_RESET_DIV)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DIV_W-1:0]  divisor_int,
    input  logic [FRAC_W-1:0] divisor_frac,
    input  logic              load,
    output logic              load_ack,
    input  logic              rx_restart,
    output logic              os_tick,
    output logic              tx_baud
);

    localparam int PHASE_W = phase_width(OVERSAMPLE);

    if (!oversample_ok(OVERSAMPLE)) begin : g_bad_oversample
        $error("uart_baud_gen: OVERSAMPLE must be a power of two in 4..64");
    end

    logic [DIV_W-1:0]   div_q, pend_div, div_next;
    logic [FRAC_W-1:0]  frac_q, pend_frac, frac_next;
    logic               pend;
    logic [DIV_W:0]     cnt, cnt_next;   // one extra bit: period can be 2^DIV_W
    logic [PHASE_W-1:0] phase;
    logic               carry;
    logic               period_done, restart, fire, apply, acc_clear;

    uart_frac_acc #(.FRAC_W(FRAC_W)) u_frac_acc (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (acc_clear),
        .tick    (fire),
        .frac    (frac_q),
        .carry   (carry)
    );

    // Period bookkeeping. cnt == 0 means idle (not yet started); while running
    // it holds the clocks left in the period and the tick fires when it hits 1.
    always_comb begin
        period_done = enable && (cnt == (DIV_W+1)'(1));
        restart     = enable && rx_restart;
        fire        = period_done && !restart;
        apply       = pend && (!enable || period_done);
        div_next    = apply ? pend_div  : div_q;
        frac_next   = apply ? pend_frac : frac_q;
        acc_clear   = !enable || restart || apply;
        cnt_next    = cnt;
        if (!enable) begin
            cnt_next = '0;
        end else if (restart || cnt == '0) begin
            // Fresh alignment: a full integer period, no fractional carry.
            cnt_next = {1'b0, div_next};
        end else if (period_done) begin
            cnt_next = {1'b0, div_next} + (DIV_W+1)'(apply ? 1'b0 : carry);
        end else begin
            cnt_next = cnt - 1'b1;
        end
    end

    // Counter, phase and registered tick outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            phase    <= '0;
            os_tick  <= 1'b0;
            tx_baud  <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            os_tick  <= fire;
            tx_baud  <= fire && (phase == PHASE_W'(OVERSAMPLE - 1));
            load_ack <= apply;
            if (!enable || restart) begin
                phase <= '0;
            end else if (fire) begin
                phase <= phase + 1'b1;
            end
        end
    end

    // Active divisor; only changes when a pending load is applied.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= RESET_DIV;
            frac_q <= '0;
        end else begin
            div_q  <= div_next;
            frac_q <= frac_next;
        end
    end

    // Pending divisor; a newer load overwrites it, so only one ack results.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend      <= 1'b0;
            pend_div  <= '0;
            pend_frac <= '0;
        end else if (load) begin
            pend      <= 1'b1;
            pend_div  <= (divisor_int == '0) ? DIV_W'(1) : divisor_int;
            pend_frac <= divisor_frac;
        end else if (apply) begin
            pend      <= 1'b0;
        end
    end

endmodule
